uart_xmit_feeder: RTL and testbench
===================================

UART_XMIT_FEEDER -- requirements
Module: uart_xmit_feeder

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, SHALL set the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL set the UART bit rate.
REQ-003 Parameter MAX_LEN, default 255, SHALL set the maximum payload bytes per frame, range 1..255.
REQ-004 Port clk, input, 1 bit, SHALL be the single system clock; all logic rising-edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-006 Port rxd, input, 1 bit, SHALL be the asynchronous UART serial input, idle high, 8N1.
REQ-007 Port xrdy, input, 1 bit, SHALL indicate the transmitter accepts a byte or send command this cycle.
REQ-008 Port xbusy, input, 1 bit, SHALL indicate the transmitter is sending a frame.
REQ-009 Port uart_in, output, 8 bits, SHALL carry the byte being presented to the transmitter.
REQ-010 Port xvalid, output, 1 bit, SHALL be a one-cycle pulse qualifying uart_in.
REQ-011 Port xsend, output, 1 bit, SHALL be a one-cycle pulse commanding frame transmission.
REQ-012 Port frame_type, output, 8 bits, SHALL hold the frame type of the current frame.
REQ-013 Port ferr, output, 1 bit, SHALL pulse one cycle on a UART framing error (stop bit low).
REQ-014 Port ovf, output, 1 bit, SHALL pulse one cycle when a received byte is dropped.

Function
REQ-015 The UART receiver SHALL sample 16x BAUD, validate the start bit at mid-bit, sample data LSB first at each bit centre, and check the stop bit.
REQ-016 The framer FSM SHALL use states IDLE, ADDR, TYPE, DATA, SEND, WAIT_BUSY.
REQ-017 IDLE: the first valid received byte is the destination address; it SHALL be presented via xvalid and the FSM SHALL go to TYPE.
REQ-018 TYPE: the next byte SHALL be latched into frame_type and not presented; the FSM goes to DATA.
REQ-019 DATA: each byte other than SEND_CHAR SHALL be presented via xvalid and the payload counter incremented.
REQ-020 DATA: on SEND_CHAR (not presented), or when the counter reaches MAX_LEN, the FSM SHALL enter SEND.
REQ-021 SEND: xsend SHALL pulse in the first cycle xrdy is high, then the FSM enters WAIT_BUSY.
REQ-022 WAIT_BUSY SHALL wait for xbusy to go high then low, then return to IDLE with the counter cleared.
REQ-023 Presenting SHALL occur in the first cycle xrdy is high, with uart_in stable that cycle; a one-byte holding register SHALL buffer the pending byte.
REQ-024 A byte received while the holding register is full, or while in SEND or WAIT_BUSY, SHALL be dropped with ovf pulsed.
REQ-025 A byte with a framing error SHALL be discarded, ferr pulsed, and the FSM state unchanged.
REQ-026 SEND_CHAR received in IDLE or TYPE SHALL be discarded; the FSM returns to IDLE.
REQ-027 Byte-complete and ovf in one cycle SHALL not occur; the receiver emits at most one byte per cycle.

Reset
REQ-028 On rst low: FSM to IDLE; counter, holding register and uart_in to 0; frame_type 8'h00; xvalid, xsend, ferr and ovf 0.
REQ-029 Reset mid-byte or mid-frame SHALL abandon the byte; the receiver resynchronises on the next falling edge after rxd is high for one bit time.

Configuration
REQ-030 With RX_GLITCH_FILTER_EN defined, rxd SHALL pass a two-flop synchroniser then a 3-sample majority filter at 16x rate, adding 2 oversample ticks latency.
REQ-031 Without RX_GLITCH_FILTER_EN, rxd SHALL pass only the two-flop synchroniser.

Structure
REQ-032 Package xfeed_pkg SHALL hold the FSM state enum, SEND_CHAR = 8'h04, and OVERSAMPLE = 16.
REQ-033 Sub-module uart_rx_core SHALL implement REQ-015, outputting data[7:0], a done pulse and a ferr pulse; the framer lives in uart_xmit_feeder.

Verification
REQ-034 UART bytes 8'h2A, 8'h30, 8'h41, 8'h42, 8'h04 with xrdy high -> xvalid with 2A, 41, 42; frame_type = 8'h30; one xsend pulse.
REQ-035 xrdy low across two data bytes -> the first is presented when xrdy rises; the second is dropped with one ovf pulse.
REQ-036 Bytes 8'h10, 8'h30, then 255 payload bytes 8'h55 -> xsend pulses after byte 255 with no SEND_CHAR; the next byte is treated as an address after xbusy falls.
REQ-037 Byte 8'h41 with stop bit low -> ferr pulses; no xvalid; the FSM state is unchanged.
REQ-038 rst low during the TYPE byte, then 8'h07, 8'h31, 8'h04 -> 07 is presented as the address; frame_type = 8'h31; xsend pulses.
REQ-039 RX_GLITCH_FILTER_EN defined, 1-oversample-tick low glitch on idle rxd -> no start detected; no outputs.

Source files
------------

// File: rtl/xfeed_pkg.sv
// Shared definitions for the UART transmit feeder.
//   SEND_CHAR    : in-band end-of-frame marker, never forwarded to the transmitter
//   OVERSAMPLE   : receiver samples per bit
//   feed_state_e : framer states
//   rx_state_e   : receiver states
//   majority3    : 2-of-3 vote used by the optional rxd glitch filter
package xfeed_pkg;

    localparam logic [7:0]  SEND_CHAR  = 8'h04;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StType,
        StData,
        StSend,
        StWaitBusy
    } feed_state_e;

    typedef enum logic [2:0] {
        RxSync,
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, 16x oversampled.
// Optional build macro: RX_GLITCH_FILTER_EN adds a 3-sample majority filter after the
// two-flop synchroniser.
// Ports:
//   clk, rst : system clock, asynchronous active-low reset
//   rxd      : asynchronous serial input, idle high
//   data     : last received byte, held until the next byte starts shifting in
//   done     : one-cycle pulse, data valid
//   ferr     : one-cycle pulse, stop bit sampled low (byte discarded)
module uart_rx_core
    import xfeed_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       done,
    output logic       ferr
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] CNT_HALF = 4'(OVERSAMPLE / 2 - 1);

    // Oversample tick generator.
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Two-flop synchroniser; reset to idle level so reset never looks like a start bit.
    logic [1:0] sync_q;
    logic       rx_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

`ifdef RX_GLITCH_FILTER_EN
    logic [1:0] samp_q;
    logic       filt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q <= 2'b11;
            filt_q <= 1'b1;
        end else if (tick) begin
            samp_q <= {samp_q[0], sync_q[1]};
            filt_q <= majority3(samp_q[1], samp_q[0], sync_q[1]);
        end
    end

    assign rx_line = filt_q;
`else
    assign rx_line = sync_q[1];
`endif

    rx_state_e  state_q;
    logic [3:0] tick_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;

    assign data = shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RxSync;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            done       <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            done <= 1'b0;
            ferr <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    // Need one full bit time of idle-high before trusting a falling edge.
                    RxSync: begin
                        if (!rx_line) begin
                            tick_cnt_q <= '0;
                        end else if (tick_cnt_q == CNT_LAST) begin
                            tick_cnt_q <= '0;
                            state_q    <= RxIdle;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                    RxIdle: begin
                        if (!rx_line) begin
                            tick_cnt_q <= '0;
                            state_q    <= RxStart;
                        end
                    end
                    // Re-check the start bit at its centre to reject glitches.
                    RxStart: begin
                        if (tick_cnt_q == CNT_HALF) begin
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            state_q    <= rx_line ? RxIdle : RxData;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                    RxData: begin
                        if (tick_cnt_q == CNT_LAST) begin
                            tick_cnt_q <= '0;
                            shift_q    <= {rx_line, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_q <= RxStop;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                    RxStop: begin
                        if (tick_cnt_q == CNT_LAST) begin
                            tick_cnt_q <= '0;
                            if (rx_line) begin
                                done    <= 1'b1;
                                state_q <= RxIdle;
                            end else begin
                                // Line may be held low (break); resync before the next start.
                                ferr    <= 1'b1;
                                state_q <= RxSync;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= RxSync;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_xmit_feeder.sv
// Receives UART bytes and reframes them for a byte-oriented transmitter:
// address byte (forwarded), frame type (latched), payload (forwarded) ended by SEND_CHAR
// or MAX_LEN bytes, then a send command and a wait for the transmitter to finish.
// Optional build macro: RX_GLITCH_FILTER_EN (majority filter on rxd, see uart_rx_core).
// Ports:
//   clk, rst   : system clock, asynchronous active-low reset
//   rxd        : UART serial input
//   xrdy       : transmitter accepts a byte or send command this cycle
//   xbusy      : transmitter is sending a frame
//   uart_in    : byte presented to the transmitter (holding register)
//   xvalid     : qualifies uart_in; high only in a cycle where xrdy is high
//   xsend      : send command; high only in a cycle where xrdy is high
//   frame_type : type byte of the current frame
//   ferr       : pulse on a receive framing error
//   ovf        : pulse when a received byte is dropped
module uart_xmit_feeder
    import xfeed_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned MAX_LEN  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       xrdy,
    input  logic       xbusy,
    output logic [7:0] uart_in,
    output logic       xvalid,
    output logic       xsend,
    output logic [7:0] frame_type,
    output logic       ferr,
    output logic       ovf
);

    localparam logic [7:0] LEN_LAST = 8'(MAX_LEN);

    logic [7:0] rx_data;
    logic       rx_done;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .data (rx_data),
        .done (rx_done),
        .ferr (ferr)
    );

    feed_state_e state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic [7:0]  frame_type_q;
    logic        seen_busy_q;
    logic        ovf_q;
    logic        present;
    logic        send_fire;

    // Handshakes complete in the same cycle xrdy is seen; the send command waits until the
    // last payload byte has left the holding register.
    assign present    = hold_full_q & xrdy;
    assign send_fire  = (state_q == StSend) & ~hold_full_q & xrdy;

    assign uart_in    = hold_q;
    assign xvalid     = present;
    assign xsend      = send_fire;
    assign frame_type = frame_type_q;
    assign ovf        = ovf_q;

    // Framing errors never reach this FSM: rx_done stays low, so the state is untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            frame_type_q <= 8'h00;
            seen_busy_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (present) begin
                hold_full_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (rx_done && (rx_data != SEND_CHAR)) begin
                        state_q <= StAddr;
                    end
                end
                // The holding register is always empty here (SEND drains it), and the
                // receiver data stays stable for many cycles after done.
                StAddr: begin
                    hold_q      <= rx_data;
                    hold_full_q <= 1'b1;
                    state_q     <= StType;
                end
                StType: begin
                    if (rx_done) begin
                        if (rx_data == SEND_CHAR) begin
                            state_q <= StIdle;
                        end else begin
                            frame_type_q <= rx_data;
                            state_q      <= StData;
                        end
                    end
                end
                StData: begin
                    if (rx_done) begin
                        if (rx_data == SEND_CHAR) begin
                            state_q <= StSend;
                        end else if (hold_full_q && !present) begin
                            ovf_q <= 1'b1;
                        end else begin
                            hold_q      <= rx_data;
                            hold_full_q <= 1'b1;
                            cnt_q       <= cnt_q + 8'd1;
                            if ((cnt_q + 8'd1) == LEN_LAST) begin
                                state_q <= StSend;
                            end
                        end
                    end
                end
                StSend: begin
                    if (rx_done) begin
                        ovf_q <= 1'b1;
                    end
                    if (send_fire) begin
                        seen_busy_q <= 1'b0;
                        state_q     <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (rx_done) begin
                        ovf_q <= 1'b1;
                    end
                    if (!seen_busy_q) begin
                        if (xbusy) begin
                            seen_busy_q <= 1'b1;
                        end
                    end else if (!xbusy) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_xmit_feeder.sv
// Self-checking bench for uart_xmit_feeder. Runs the DUT at 16 clocks per bit so a full
// MAX_LEN frame fits comfortably in simulation.
module tb_uart_xmit_feeder;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned MAX_LEN  = 255;
    localparam int          BIT_CLKS = CLK_FREQ / BAUD;
    localparam int          GAP_CLKS = 20;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       xrdy;
    logic       xbusy;
    logic [7:0] uart_in;
    logic       xvalid;
    logic       xsend;
    logic [7:0] frame_type;
    logic       ferr;
    logic       ovf;

    uart_xmit_feeder #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .xrdy       (xrdy),
        .xbusy      (xbusy),
        .uart_in    (uart_in),
        .xvalid     (xvalid),
        .xsend      (xsend),
        .frame_type (frame_type),
        .ferr       (ferr),
        .ovf        (ovf)
    );

    int n_cmp;
    int n_err;

    // Observations collected away from the clock edge.
    logic [7:0] got_q[$];
    int         n_xsend;
    int         n_ovf;
    int         n_ferr;
    int         n_bad_xvalid;

    // Reference model state (byte-level framing rules).
    int         m_phase;  // 0: waiting address, 1: waiting type, 2: payload
    int         m_cnt;
    logic [7:0] exp_q[$];
    int         exp_send;
    int         exp_ferr;
    logic [7:0] exp_ft;

    int xrdy_mode;  // 0: always high, 1: random, 2: held low

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        xrdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (xrdy_mode)
                0:       xrdy = 1'b1;
                1:       xrdy = ($urandom_range(0, 3) != 0);
                default: xrdy = 1'b0;
            endcase
        end
    end

    // Transmitter stand-in: goes busy shortly after a send command.
    initial begin
        xbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (xsend) begin
                repeat (3) @(posedge clk);
                #1 xbusy = 1'b1;
                repeat (20) @(posedge clk);
                #1 xbusy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (xvalid) begin
                got_q.push_back(uart_in);
                if (!xrdy) n_bad_xvalid++;
            end
            if (xsend) n_xsend++;
            if (ovf) n_ovf++;
            if (ferr) n_ferr++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic clear_obs();
        got_q.delete();
        n_xsend      = 0;
        n_ovf        = 0;
        n_ferr       = 0;
        n_bad_xvalid = 0;
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_cnt    = 0;
        exp_q.delete();
        exp_send = 0;
        exp_ferr = 0;
        exp_ft   = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            exp_ferr++;
            return;
        end
        case (m_phase)
            0: begin
                if (b != 8'h04) begin
                    exp_q.push_back(b);
                    m_phase = 1;
                end
            end
            1: begin
                if (b == 8'h04) begin
                    m_phase = 0;
                end else begin
                    exp_ft  = b;
                    m_cnt   = 0;
                    m_phase = 2;
                end
            end
            default: begin
                if (b == 8'h04) begin
                    exp_send++;
                    m_phase = 0;
                end else begin
                    exp_q.push_back(b);
                    m_cnt++;
                    if (m_cnt == MAX_LEN) begin
                        exp_send++;
                        m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    // Called and returns at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        logic [9:0] frame;
        frame = {~bad_stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (GAP_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b, input bit bad);
        model_byte(b, bad);
        send_byte(b, bad);
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        clear_obs();
        model_reset();
    endtask

    task automatic test_reset();
        rxd = 1'b1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({uart_in, xvalid, xsend, frame_type, ferr, ovf} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got uart_in=%h xvalid=%b xsend=%b type=%h ferr=%b ovf=%b, required all 0",
                     uart_in, xvalid, xsend, frame_type, ferr, ovf);
        end
        rst = 1'b1;
        clear_obs();
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() + n_xsend + n_ovf + n_ferr !== 0) begin
            n_err++;
            $display("FAIL reset_idle_quiet: got %0d events after reset, required 0",
                     got_q.size() + n_xsend + n_ovf + n_ferr);
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp[3];
        exp = '{8'h2A, 8'h41, 8'h42};
        do_reset();
        send_byte(8'h2A, 0);
        send_byte(8'h30, 0);
        send_byte(8'h41, 0);
        send_byte(8'h42, 0);
        send_byte(8'h04, 0);
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() !== 3) begin
            n_err++;
            $display("FAIL basic_count: got %0d bytes, required 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (((got_q.size() > i) ? got_q[i] : 8'hxx) !== exp[i]) begin
                n_err++;
                $display("FAIL basic_byte%0d: got %h, required %h", i,
                         (got_q.size() > i) ? got_q[i] : 8'hxx, exp[i]);
            end
        end
        n_cmp++;
        if (frame_type !== 8'h30) begin
            n_err++;
            $display("FAIL basic_type: got %h, required 30", frame_type);
        end
        n_cmp++;
        if (n_xsend !== 1) begin
            n_err++;
            $display("FAIL basic_xsend: got %0d pulses, required 1", n_xsend);
        end
        n_cmp++;
        if (n_ovf + n_ferr + n_bad_xvalid !== 0) begin
            n_err++;
            $display("FAIL basic_clean: got ovf=%0d ferr=%0d bad_xvalid=%0d, required 0",
                     n_ovf, n_ferr, n_bad_xvalid);
        end
    endtask

    task automatic test_stall_ovf();
        do_reset();
        send_byte(8'h2A, 0);
        send_byte(8'h30, 0);
        xrdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h41, 0);
        send_byte(8'h42, 0);
        n_cmp++;
        if (n_ovf !== 1) begin
            n_err++;
            $display("FAIL stall_ovf: got %0d ovf pulses, required 1", n_ovf);
        end
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_err++;
            $display("FAIL stall_held: got %0d bytes while stalled, required 1", got_q.size());
        end
        xrdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (((got_q.size() == 2) ? got_q[1] : 8'hxx) !== 8'h41) begin
            n_err++;
            $display("FAIL stall_release: got %0d bytes last %h, required 2 bytes last 41",
                     got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx);
        end
        send_byte(8'h04, 0);
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if ({n_xsend, n_ovf} !== {32'd1, 32'd1}) begin
            n_err++;
            $display("FAIL stall_end: got xsend=%0d ovf=%0d, required 1 and 1", n_xsend, n_ovf);
        end
    endtask

    task automatic test_max_len();
        int n_wrong;
        do_reset();
        send_byte(8'h10, 0);
        send_byte(8'h30, 0);
        for (int i = 0; i < 255; i++) send_byte(8'h55, 0);
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (n_xsend !== 1) begin
            n_err++;
            $display("FAIL maxlen_xsend: got %0d pulses, required 1", n_xsend);
        end
        n_cmp++;
        if (got_q.size() !== 256) begin
            n_err++;
            $display("FAIL maxlen_count: got %0d bytes, required 256", got_q.size());
        end
        n_wrong = 0;
        foreach (got_q[i]) begin
            if (got_q[i] !== ((i == 0) ? 8'h10 : 8'h55)) n_wrong++;
        end
        n_cmp++;
        if (n_wrong !== 0) begin
            n_err++;
            $display("FAIL maxlen_data: got %0d wrong bytes, required 0", n_wrong);
        end
        send_byte(8'h77, 0);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (((got_q.size() == 257) ? got_q[256] : 8'hxx) !== 8'h77) begin
            n_err++;
            $display("FAIL maxlen_next_addr: got %0d bytes, required 257 ending in 77",
                     got_q.size());
        end
        n_cmp++;
        if ({n_xsend, n_ovf} !== {32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL maxlen_tail: got xsend=%0d ovf=%0d, required 1 and 0", n_xsend, n_ovf);
        end
    endtask

    task automatic test_framing_error();
        do_reset();
        xfer(8'h41, 1);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if ({n_ferr, 32'(got_q.size())} !== {32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL ferr_idle: got ferr=%0d bytes=%0d, required 1 and 0",
                     n_ferr, got_q.size());
        end
        xfer(8'h2A, 0);
        xfer(8'h30, 0);
        xfer(8'h41, 1);
        xfer(8'h42, 0);
        xfer(8'h04, 0);
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (n_ferr !== exp_ferr) begin
            n_err++;
            $display("FAIL ferr_count: got %0d, required %0d", n_ferr, exp_ferr);
        end
        n_cmp++;
        if (got_q !== exp_q) begin
            n_err++;
            $display("FAIL ferr_bytes: got %p, required %p", got_q, exp_q);
        end
        n_cmp++;
        if ({n_xsend, 24'h0, frame_type} !== {exp_send, 24'h0, exp_ft}) begin
            n_err++;
            $display("FAIL ferr_frame: got xsend=%0d type=%h, required %0d and %h",
                     n_xsend, frame_type, exp_send, exp_ft);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_byte(8'h2A, 0);
        send_byte(8'h30, 0);
        send_byte(8'h04, 0);
        repeat (60) @(posedge clk);
        #1;
        send_byte(8'h11, 0);
        // Start bit and two data bits of a type byte, then reset.
        rxd = 1'b0;
        repeat (3 * BIT_CLKS) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (frame_type !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_type: got %h, required 00", frame_type);
        end
        rxd = 1'b1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        clear_obs();
        send_byte(8'h07, 0);
        send_byte(8'h31, 0);
        send_byte(8'h04, 0);
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (((got_q.size() == 1) ? got_q[0] : 8'hxx) !== 8'h07) begin
            n_err++;
            $display("FAIL midreset_addr: got %0d bytes first %h, required one byte 07",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        n_cmp++;
        if ({n_xsend, 24'h0, frame_type} !== {32'd1, 24'h0, 8'h31}) begin
            n_err++;
            $display("FAIL midreset_frame: got xsend=%0d type=%h, required 1 and 31",
                     n_xsend, frame_type);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        rxd = 1'b0;
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() + n_xsend + n_ovf + n_ferr !== 0) begin
            n_err++;
            $display("FAIL glitch_quiet: got %0d events, required 0",
                     got_q.size() + n_xsend + n_ovf + n_ferr);
        end
        send_byte(8'h2A, 0);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (((got_q.size() == 1) ? got_q[0] : 8'hxx) !== 8'h2A) begin
            n_err++;
            $display("FAIL glitch_recover: got %0d bytes, required one byte 2A", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         len;
        do_reset();
        xrdy_mode = 1;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 4) == 0) xfer(8'h04, 0);
            b = 8'($urandom_range(0, 255));
            if (b == 8'h04) b = 8'h05;
            xfer(b, 0);
            if ($urandom_range(0, 5) == 0) begin
                xfer(8'h04, 0);
                continue;
            end
            b = 8'($urandom_range(0, 255));
            if (b == 8'h04) b = 8'h06;
            xfer(b, 0);
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) xfer(8'($urandom_range(0, 255)), 1);
                b = 8'($urandom_range(0, 255));
                if (b == 8'h04) b = 8'h44;
                xfer(b, 0);
            end
            xfer(8'h04, 0);
            repeat (40) @(posedge clk);
            #1;
        end
        xrdy_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_cmp++;
            if (((got_q.size() > i) ? got_q[i] : 8'hxx) !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_byte%0d: got %h, required %h", i,
                         (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_cmp++;
        if ({n_xsend, n_ferr, n_ovf} !== {exp_send, exp_ferr, 32'd0}) begin
            n_err++;
            $display("FAIL rand_events: got xsend=%0d ferr=%0d ovf=%0d, required %0d %0d 0",
                     n_xsend, n_ferr, n_ovf, exp_send, exp_ferr);
        end
        n_cmp++;
        if (frame_type !== exp_ft) begin
            n_err++;
            $display("FAIL rand_type: got %h, required %h", frame_type, exp_ft);
        end
        n_cmp++;
        if (n_bad_xvalid !== 0) begin
            n_err++;
            $display("FAIL rand_handshake: got %0d xvalid without xrdy, required 0",
                     n_bad_xvalid);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        rxd       = 1'b1;
        xrdy_mode = 0;
        clear_obs();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_basic_frame();
        test_stall_ovf();
        test_max_len();
        test_framing_error();
        test_reset_midframe();
        test_glitch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
